sha_byte_loader: RTL and testbench
==================================

Name: sha_byte_loader

Overview:
Upstream fill stage for the 32-byte SHA message/digest register file.
- Accepts a byte stream over a valid/ready handshake and writes each byte into the register file through its en/wr/addr/data_in write port.
- Zero-pads short blocks.
- Presents a complete 32-byte block to the hash core with blk_valid/blk_ack, holding off new input until the core has consumed the block.

Parameters:
NUM_BYTES, 32, bytes per block; equals register-file depth.
ADDR_W, 5, register-file address width; equals log2(NUM_BYTES).
REVERSE, 0, 0: first byte goes to addr 0, ascending. 1: first byte goes to addr NUM_BYTES-1, descending.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high; clock clk
in_valid  in  1  upstream byte valid
in_ready  out  1  loader can accept a byte
in_data  in  8  upstream byte
in_last  in  1  final byte of message; qualified by in_valid
abort  in  1  synchronous flush of the current block
blk_valid  out  1  full block resident in register file
blk_ack  in  1  hash core has consumed the block
blk_len  out  6  count of real (non-pad) bytes in the block, 1..32
rf_en  out  1  register-file enable
rf_wr  out  1  register-file write strobe
rf_addr  out  ADDR_W  register-file address
rf_wdata  out  8  register-file write data

Behaviour:
- Reset values: state=FILL, ptr=0, blk_len=0, blk_valid=0, rf_en=0, rf_wr=0, rf_addr=0, rf_wdata=0. in_ready=0 while rst is high. The register file is cleared by the same rst.
- Accept rule: a byte is accepted at a rising edge where in_valid && in_ready. in_ready = (state==FILL) && !rst && !abort.
- Write timing: rf_en, rf_wr, rf_addr and rf_wdata are registered.
  - Edge E_k accepts a byte; the write strobe is driven during cycle k+1 and the register file captures at E_{k+1}.
  - rf_en=rf_wr=1 for exactly one cycle per byte; both are 0 otherwise.
- Address: physical addr = REVERSE ? (NUM_BYTES-1-ptr) : ptr. ptr increments by 1 per written byte, real or pad, and never wraps within a block.
- FILL:
  - On accept, write the byte and increment ptr; blk_len is set to ptr+1.
  - Byte accepted with ptr==31, with or without in_last → COMMIT.
  - in_last accepted with ptr<31 → PAD.
- PAD:
  - in_ready=0.
  - One zero byte is issued per cycle (same registered timing) at ptr+1 .. 31.
  - blk_len is frozen.
  - After the byte at ptr 31 is issued → COMMIT.
- COMMIT: single cycle; waits for the final registered write to land. → HOLD.
- HOLD:
  - blk_valid=1, in_ready=0. blk_len is stable.
  - On blk_ack: blk_valid falls next cycle, ptr=0, blk_len=0, → FILL.
  - in_valid present in the ack cycle is not accepted. The earliest accept is the edge after the return to FILL.
- Latency: the final real byte is accepted at edge E, and blk_valid is high after E+2 when there is no padding. With padding of p bytes, blk_valid is high after E+2+p.
- abort (any state):
  - Next state=FILL, ptr=0, blk_len=0, blk_valid=0.
  - A write strobe already driven in the current cycle completes.
  - No further writes are issued; stale bytes remain in the register file.
  - abort has priority over in_valid, in_last and blk_ack in the same cycle.
- blk_ack outside HOLD is ignored.
- rst mid-block: all state returns to reset values at the next edge; partial data is discarded.
- in_last is ignored unless accepted.

Decomposition:
- Shared package sha_sram_pkg holds: NUM_BYTES, ADDR_W, byte_t (8-bit), and the state enum {FILL, PAD, COMMIT, HOLD}.
- Single flat module; no sub-module. The address-reversal function lives in the package.

Test Plan:
1. Full block: 32 bytes 0x00..0x1F, in_valid held high, REVERSE=0 → 32 consecutive strobes at addr 0..31. blk_valid rises 2 cycles after the last accept, blk_len=32. reg_out[7:0]=0x00 and reg_out[255:248]=0x1F.
2. Short block: 5 bytes 0xA1..0xA5, in_last on 0xA5 → 27 zero writes at addr 5..31 on consecutive cycles. blk_len=5, blk_valid 29 cycles after the last accept. reg_out[255:40]=0.
3. Backpressure: hold blk_ack=0 for 10 cycles in HOLD, in_valid=1 → in_ready=0 throughout, no rf strobes. Pulse blk_ack → next block's first byte written to addr 0.
4. Abort: after 12 bytes, assert abort with in_valid=1 → that byte is not accepted, and only the strobe already in flight completes. Next byte 0x55 is written to addr 0. blk_valid never rises.
5. REVERSE=1: bytes 0x10, 0x11, 0x12 with in_last → writes at addr 31, 30, 29, then zeros at 28..0. blk_len=3.
6. Reset mid-fill: rst for 1 cycle after 7 bytes → all outputs at reset values, reg_out=0. Refill of 32 bytes behaves as scenario 1.

Source files
------------

// File: rtl/sha_sram_pkg.sv
// Shared definitions for the SHA message/digest register-file fill path.
//   NUM_BYTES : bytes per block (register-file depth)
//   ADDR_W    : register-file address width
//   byte_t    : one message byte
//   state_t   : loader FSM states
//   phys_addr : maps a fill pointer to a register-file address
package sha_sram_pkg;

  localparam int NUM_BYTES = 32;
  localparam int ADDR_W    = 5;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PAD    = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Ascending placement puts the first byte at address 0; reversed
  // placement puts it at the top of the register file.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [ADDR_W-1:0] ptr,
                                                  input logic              reverse);
    return reverse ? (ADDR_W'(NUM_BYTES - 1) - ptr) : ptr;
  endfunction

endpackage

// File: rtl/sha_byte_loader.sv
// Upstream fill stage for the 32-byte SHA register file.
// Takes a byte stream, writes each byte through the register-file write
// port, zero-pads short blocks and hands a full block to the hash core.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   byte handshake; in_data byte, in_last marks final byte
//   abort               synchronous flush of the current block
//   blk_valid/blk_ack   full block resident / consumed by the core
//   blk_len             real (non-pad) bytes in the block
//   rf_en/rf_wr/rf_addr/rf_wdata  registered register-file write port
//   dbg_state           current FSM state (sha_sram_pkg::state_t encoding)
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready
// are both high; in_ready never depends on in_valid, and the source must hold
// in_data/in_last stable while in_valid is high and in_ready is low.
module sha_byte_loader #(
  parameter int NUM_BYTES = 32,
  parameter int ADDR_W    = 5,
  parameter int REVERSE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              abort,
  output logic              blk_valid,
  input  logic              blk_ack,
  output logic [5:0]        blk_len,
  output logic              rf_en,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_wdata,
  output logic [1:0]        dbg_state
);
  import sha_sram_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;

  assign in_ready  = (state == FILL) && !rst && !abort;
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      ptr       <= '0;
      blk_len   <= '0;
      blk_valid <= 1'b0;
      rf_en     <= 1'b0;
      rf_wr     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
    end else begin
      // Write strobes are single-cycle pulses.
      rf_en <= 1'b0;
      rf_wr <= 1'b0;
      if (abort) begin
        // A strobe already on the port this cycle still lands; nothing new
        // is issued and stale bytes are left in the register file.
        state     <= FILL;
        ptr       <= '0;
        blk_len   <= '0;
        blk_valid <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (accept) begin
              rf_en    <= 1'b1;
              rf_wr    <= 1'b1;
              rf_addr  <= phys_addr(ptr, REVERSE != 0);
              rf_wdata <= in_data;
              blk_len  <= 6'(ptr) + 6'd1;
              if (ptr == LAST_PTR) begin
                state <= COMMIT;
              end else begin
                ptr <= ptr + ADDR_W'(1);
                if (in_last) state <= PAD;
              end
            end
          end
          PAD: begin
            // ptr already points one past the last real byte.
            rf_en    <= 1'b1;
            rf_wr    <= 1'b1;
            rf_addr  <= phys_addr(ptr, REVERSE != 0);
            rf_wdata <= '0;
            if (ptr == LAST_PTR) state <= COMMIT;
            else                 ptr   <= ptr + ADDR_W'(1);
          end
          COMMIT: begin
            // On entry the final strobe is still on the port; the block is
            // only announced once that write has landed.
            if (!rf_en) begin
              state     <= HOLD;
              blk_valid <= 1'b1;
            end
          end
          HOLD: begin
            if (blk_ack) begin
              state     <= FILL;
              blk_valid <= 1'b0;
              ptr       <= '0;
              blk_len   <= '0;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha_byte_loader.sv
// Self-checking bench for sha_byte_loader. Two instances share one stimulus
// stream: u_fwd (ascending placement) and u_rev (descending placement).
module tb_sha_byte_loader;
  import sha_sram_pkg::*;

  localparam int NB = 32;

  // ---------------- clock / reset / shared inputs ----------------
  logic clk = 1'b0;
  logic rst, in_valid, in_last, abort, blk_ack;
  logic [7:0] in_data;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- DUT outputs ----------------
  logic       f_in_ready, f_blk_valid, f_rf_en, f_rf_wr;
  logic [5:0] f_blk_len;
  logic [4:0] f_rf_addr;
  logic [7:0] f_rf_wdata;
  logic [1:0] f_state;
  logic       r_in_ready, r_blk_valid, r_rf_en, r_rf_wr;
  logic [5:0] r_blk_len;
  logic [4:0] r_rf_addr;
  logic [7:0] r_rf_wdata;
  logic [1:0] r_state;

  sha_byte_loader #(.NUM_BYTES(32), .ADDR_W(5), .REVERSE(0)) u_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_data(in_data), .in_last(in_last), .abort(abort),
    .blk_valid(f_blk_valid), .blk_ack(blk_ack), .blk_len(f_blk_len),
    .rf_en(f_rf_en), .rf_wr(f_rf_wr), .rf_addr(f_rf_addr),
    .rf_wdata(f_rf_wdata), .dbg_state(f_state));

  sha_byte_loader #(.NUM_BYTES(32), .ADDR_W(5), .REVERSE(1)) u_rev (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_data(in_data), .in_last(in_last), .abort(abort),
    .blk_valid(r_blk_valid), .blk_ack(blk_ack), .blk_len(r_blk_len),
    .rf_en(r_rf_en), .rf_wr(r_rf_wr), .rf_addr(r_rf_addr),
    .rf_wdata(r_rf_wdata), .dbg_state(r_state));

  // ---------------- register files driven by the DUT write ports ----------------
  logic [7:0] rf_f [NB];
  logic [7:0] rf_r [NB];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        rf_f[i] <= 8'h00;
        rf_r[i] <= 8'h00;
      end
    end else begin
      if (f_rf_en && f_rf_wr) rf_f[f_rf_addr] <= f_rf_wdata;
      if (r_rf_en && r_rf_wr) rf_r[r_rf_addr] <= r_rf_wdata;
    end
  end

  function automatic logic [255:0] pack_rf(input logic [7:0] a [NB]);
    logic [255:0] v;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = a[i];
    return v;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [7:0]  msg [NB];           // current message bytes
  logic [12:0] exp_q_f[$];         // expected {addr,data} writes, ascending DUT
  logic [12:0] exp_q_r[$];         // expected {addr,data} writes, descending DUT
  int          strobe_q[$];        // edge numbers of observed ascending strobes
  int          strobe_total = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte i of a block lands at i (ascending) or 31-i (descending); bytes at
  // or past the real length are zero.
  task automatic expect_writes(input int n_real, input int n_total);
    logic [7:0] d;
    for (int i = 0; i < n_total; i++) begin
      d = (i < n_real) ? msg[i] : 8'h00;
      exp_q_f.push_back({5'(i), d});
      exp_q_r.push_back({5'(NB - 1 - i), d});
    end
  endtask

  function automatic logic [255:0] exp_img(input bit rev, input int n);
    logic [255:0] v;
    int a;
    v = '0;
    for (int i = 0; i < NB; i++) begin
      a = rev ? (NB - 1 - i) : i;
      v[8*a +: 8] = (i < n) ? msg[i] : 8'h00;
    end
    return v;
  endfunction

  // Write-port monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (f_rf_en || f_rf_wr) begin
      chk("f_rf_en", f_rf_en, 1'b1);
      chk("f_rf_wr", f_rf_wr, 1'b1);
      strobe_q.push_back(edge_n);
      strobe_total++;
      chk("f_write_expected", exp_q_f.size() != 0, 1'b1);
      if (exp_q_f.size() != 0) chk("f_write", {f_rf_addr, f_rf_wdata}, exp_q_f.pop_front());
    end
    if (r_rf_en || r_rf_wr) begin
      chk("r_rf_en", r_rf_en, 1'b1);
      chk("r_rf_wr", r_rf_wr, 1'b1);
      chk("r_write_expected", exp_q_r.size() != 0, 1'b1);
      if (exp_q_r.size() != 0) chk("r_write", {r_rf_addr, r_rf_wdata}, exp_q_r.pop_front());
    end
  end

  // ---------------- driver tasks (enter/leave 1 time unit after posedge) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int first);
    for (int i = first; i < NB; i++) msg[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blk_valid"}, {f_blk_valid, r_blk_valid}, 2'b00);
    chk({tag, "_blk_len"}, {f_blk_len, r_blk_len}, 12'h000);
    chk({tag, "_rf_strobe"}, {f_rf_en, f_rf_wr, r_rf_en, r_rf_wr}, 4'h0);
    chk({tag, "_rf_addr_data"}, {f_rf_addr, f_rf_wdata, r_rf_addr, r_rf_wdata}, 26'h0);
    chk({tag, "_state"}, {f_state, r_state}, {FILL, FILL});
  endtask

  task automatic drive_bytes(input int n, input bit with_last, output int last_acc);
    last_acc = -1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = with_last && (i == n - 1);
      blk_ack  = 1'($urandom_range(0, 1));   // ignored outside HOLD
      @(negedge clk);
      chk("fill_blk_len", {f_blk_len, r_blk_len}, {6'(i), 6'(i)});
      chk("fill_in_ready", {f_in_ready, r_in_ready}, 2'b11);
      last_acc = edge_n + 1;
      step();
    end
    blk_ack = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic check_hold(input int n);
    chk("hold_blk_valid", {f_blk_valid, r_blk_valid}, 2'b11);
    chk("hold_blk_len", {f_blk_len, r_blk_len}, {6'(n), 6'(n)});
    chk("hold_in_ready", {f_in_ready, r_in_ready}, 2'b00);
    chk("hold_state", {f_state, r_state}, {HOLD, HOLD});
    chk("hold_writes_left", exp_q_f.size() + exp_q_r.size(), 0);
    chk("f_reg_out", pack_rf(rf_f), exp_img(1'b0, n));
    chk("r_reg_out", pack_rf(rf_r), exp_img(1'b1, n));
  endtask

  // Streams a block with in_valid held high and checks it arrives in HOLD.
  task automatic run_block(input int n, input bit with_last);
    int acc, rise, exp_rise;
    strobe_q.delete();
    expect_writes(n, NB);
    drive_bytes(n, with_last, acc);
    in_data  = 8'($urandom_range(0, 255));
    exp_rise = acc + 2 + (NB - n);
    rise = -1;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (f_blk_valid) begin
        rise = edge_n;
        break;
      end
    end
    chk("blk_valid_latency", rise, exp_rise);
    check_hold(n);
    chk("strobe_count", strobe_q.size(), NB);
    chk("strobe_span", (strobe_q.size() > 0) ? strobe_q[$] - strobe_q[0] : -1, NB - 1);
    step();
  endtask

  task automatic ack_block();
    blk_ack = 1'b1;
    @(negedge clk);
    chk("ack_in_ready", {f_in_ready, r_in_ready}, 2'b00);
    chk("ack_blk_valid", {f_blk_valid, r_blk_valid}, 2'b11);
    step();
    blk_ack = 1'b0;
    chk("post_ack_blk_valid", {f_blk_valid, r_blk_valid}, 2'b00);
    chk("post_ack_blk_len", {f_blk_len, r_blk_len}, 12'h000);
    chk("post_ack_state", {f_state, r_state}, {FILL, FILL});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc, n0, n;
    bit wl;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0; blk_ack = 1'b0;
    in_data = 8'h00;
    step();
    step();
    chk("rst_in_ready", {f_in_ready, r_in_ready}, 2'b00);
    check_reset_outputs("rst");
    chk("rst_reg_out", {pack_rf(rf_f), pack_rf(rf_r)} != '0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {f_in_ready, r_in_ready}, 2'b11);
    step();

    // Full block 0x00..0x1F, no padding.
    for (int i = 0; i < NB; i++) msg[i] = 8'(i);
    run_block(NB, 1'b0);
    chk("full_byte0", rf_f[0], 8'h00);
    chk("full_byte31", rf_f[31], 8'h1F);
    ack_block();

    // Short block 0xA1..0xA5 padded with 27 zeros.
    for (int i = 0; i < 5; i++) msg[i] = 8'hA1 + 8'(i);
    run_block(5, 1'b1);
    chk("short_pad_zero", pack_rf(rf_f) >> 40, 256'h0);

    // Backpressure: sit in HOLD with a byte (and a stray in_last) offered.
    in_valid = 1'b1;
    in_last  = 1'b1;
    n0 = strobe_total;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_in_ready", {f_in_ready, r_in_ready}, 2'b00);
      chk("bp_blk_valid", {f_blk_valid, r_blk_valid}, 2'b11);
      step();
    end
    chk("bp_no_strobes", strobe_total - n0, 0);
    fill_random(0);
    in_last = 1'b0;
    in_data = msg[0];
    ack_block();
    n = $urandom_range(1, NB);
    run_block(n, 1'b1);
    ack_block();

    // Abort after 12 bytes with another byte on offer.
    fill_random(0);
    strobe_q.delete();
    expect_writes(12, 12);
    drive_bytes(12, 1'b0, acc);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    abort    = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", {f_in_ready, r_in_ready}, 2'b00);
    chk("abort_inflight_strobe", {f_rf_en, r_rf_en}, 2'b11);
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_no_strobe", {f_rf_en, r_rf_en}, 2'b00);
    chk("abort_blk_len", {f_blk_len, r_blk_len}, 12'h000);
    chk("abort_blk_valid", {f_blk_valid, r_blk_valid}, 2'b00);
    chk("abort_state", {f_state, r_state}, {FILL, FILL});
    chk("abort_writes_left", exp_q_f.size() + exp_q_r.size(), 0);
    fill_random(0);
    msg[0] = 8'h55;
    n = $urandom_range(1, NB - 1);
    run_block(n, 1'b1);
    ack_block();

    // Three bytes with in_last; the descending instance covers 31,30,29 then 28..0.
    msg[0] = 8'h10; msg[1] = 8'h11; msg[2] = 8'h12;
    run_block(3, 1'b1);
    chk("rev_top_bytes", {rf_r[31], rf_r[30], rf_r[29], rf_r[28]}, 32'h10111200);
    ack_block();

    // Reset in the middle of a fill.
    fill_random(0);
    expect_writes(7, 7);
    drive_bytes(7, 1'b0, acc);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {f_in_ready, r_in_ready}, 2'b00);
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    chk("midrst_reg_out", {pack_rf(rf_f), pack_rf(rf_r)} != '0, 1'b0);
    chk("midrst_writes_left", exp_q_f.size() + exp_q_r.size(), 0);
    for (int i = 0; i < NB; i++) msg[i] = 8'(i);
    run_block(NB, 1'b0);
    ack_block();

    // Random blocks, some with a few idle HOLD cycles before the ack.
    for (int b = 0; b < 6; b++) begin
      fill_random(0);
      n  = $urandom_range(1, NB);
      wl = (n < NB) ? 1'b1 : 1'($urandom_range(0, 1));
      run_block(n, wl);
      in_valid = 1'($urandom_range(0, 1));
      for (int t = 0; t < int'($urandom_range(0, 3)); t++) step();
      ack_block();
    end
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
